// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int unsigned DATA_W              = 32;
    localparam int unsigned BE_W                = DATA_W / 8;
    localparam int unsigned DEFAULT_DEPTH_WORDS = 64;
    localparam int unsigned ADDR_LSB            = 2;
    localparam int unsigned CNT_W               = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Replace only the byte lanes of old_w selected by be with the lanes of new_w.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int unsigned i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: byte-enabled synchronous write, asynchronous read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int unsigned IDX_W       = 6
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [BE_W-1:0]   be_i,
    output logic [DATA_W-1:0] rdata_c
);

    // Contents start at zero at power-up and are deliberately not touched by reset.
    logic [DATA_W-1:0] mem_q [DEPTH_WORDS] = '{default: '0};
    logic              in_range_c;

    // Guard against index values past a non-power-of-two depth.
    assign in_range_c = 32'(addr_i) < DEPTH_WORDS;
    assign rdata_c    = in_range_c ? mem_q[addr_i] : '0;

    // Byte-lane merge on write.
    always_ff @(posedge clk) begin
        if (we_i && in_range_c) begin
            mem_q[addr_i] <= merge_bytes(mem_q[addr_i], wdata_i, be_i);
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a fixed wait-state latency.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, err_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              req_ready_q, rsp_valid_q, rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic              req_err_c;
    logic [IDX_W-1:0]  req_idx_c;
    logic              accept_c, enter_resp_c, mem_we_c;
    logic              cmt_we_c, cmt_err_c;
    logic [IDX_W-1:0]  cmt_idx_c;
    logic [DATA_W-1:0] cmt_wdata_c, rd_data_c;
    logic [BE_W-1:0]   cmt_be_c;

    // Classify the live request: misaligned or beyond the array is an error.
    assign req_idx_c = req_addr[ADDR_LSB +: IDX_W];
    assign req_err_c = (req_addr[ADDR_LSB-1:0] != '0) ||
                       (32'(req_addr >> ADDR_LSB) >= 32'(DEPTH_WORDS));

    // Transaction being completed: live inputs when leaving IDLE directly, else the latched copy.
    always_comb begin
        if (state_q == IDLE) begin
            cmt_we_c    = req_we;
            cmt_err_c   = req_err_c;
            cmt_idx_c   = req_idx_c;
            cmt_wdata_c = req_wdata;
            cmt_be_c    = req_be;
        end else begin
            cmt_we_c    = we_q;
            cmt_err_c   = err_q;
            cmt_idx_c   = idx_q;
            cmt_wdata_c = wdata_q;
            cmt_be_c    = be_q;
        end
    end

    // Next-state, wait counter and response payload.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rsp_err_d    = rsp_err_q;
        rsp_rdata_d  = rsp_rdata_q;
        accept_c     = 1'b0;
        enter_resp_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept_c = 1'b1;
                    cnt_d    = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                    end else begin
                        state_d      = RESP;
                        enter_resp_c = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = RESP;
                    enter_resp_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter_resp_c) begin
            rsp_err_d   = cmt_err_c;
            rsp_rdata_d = (cmt_we_c || cmt_err_c) ? '0 : rd_data_c;
        end
    end

    // A write commits only on the edge entering RESP and never under reset.
    assign mem_we_c = enter_resp_c && cmt_we_c && !cmt_err_c && !reset;

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= (state_d == IDLE);
            rsp_valid_q <= (state_d == RESP);
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Request capture on acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept_c) begin
            we_q    <= req_we;
            err_q   <= req_err_c;
            idx_q   <= req_idx_c;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we_c),
        .addr_i  (cmt_idx_c),
        .wdata_i (cmt_wdata_c),
        .be_i    (cmt_be_c),
        .rdata_c (rd_data_c)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: vector table, corner-case sequences and a random phase against a word-array model.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned WS    = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_be;
    logic        req_valid1, req_ready1, req_we1, rsp_valid1, rsp_ready1, rsp_err1;
    logic [31:0] req_addr1, req_wdata1, rsp_rdata1;
    logic [3:0]  req_be1;

    int total = 0;
    int bad   = 0;
    logic [31:0] mem_m [DEPTH];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          stall;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0ws (
        .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
        .req_addr(req_addr1), .req_wdata(req_wdata1), .req_be(req_be1), .rsp_valid(rsp_valid1),
        .rsp_ready(rsp_ready1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: a plain word array; errors leave it alone, writes merge enabled bytes.
    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic [31:0] rd, output logic err);
        int unsigned w;
        err = (addr % 4 != 0) || (addr / 4 >= DEPTH);
        rd  = '0;
        if (!err) begin
            w = addr / 4;
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mem_m[w][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                rd = mem_m[w];
            end
        end
    endtask

    // One full transaction on the WAIT_STATES=1 instance with optional response back-pressure.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int stall, input logic [31:0] exp_rd,
                        input logic exp_err, input string tag);
        int n;
        int lat;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) begin
            chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        // Junk request kept valid while busy; it must be ignored.
        req_we = 1'b1; req_addr = 32'($urandom_range(0, DEPTH - 1) * 4); req_wdata = $urandom; req_be = 4'hF;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
        chk({tag, "_latency"}, 32'(lat), 32'(WS + 1));
        chk({tag, "_rdata"}, rsp_rdata, exp_rd);
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_hold_rdata"}, rsp_rdata, exp_rd);
            chk({tag, "_hold_err"}, 32'(rsp_err), 32'(exp_err));
            chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_done_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        logic [31:0] a;
        int          n;
        int          acc;
        bit          prev_acc;
        bit          first;

        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

        vecs[0]  = '{1'b1, 32'h10,       32'h12345678, 4'b1111, 0, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,       32'h0,        4'b1111, 5, 32'h12345678, 1'b0};
        vecs[2]  = '{1'b1, 32'h10,       32'hAABBCCDD, 4'b0101, 0, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'h10,       32'h0,        4'b0000, 0, 32'h12BB56DD, 1'b0};
        vecs[4]  = '{1'b0, 32'h13,       32'h0,        4'b1111, 0, 32'h0,        1'b1};
        vecs[5]  = '{1'b1, 32'h100,      32'hDEADBEEF, 4'b1111, 0, 32'h0,        1'b1};
        vecs[6]  = '{1'b0, 32'h10,       32'h0,        4'b1111, 1, 32'h12BB56DD, 1'b0};
        vecs[7]  = '{1'b1, 32'h14,       32'h55555555, 4'b0000, 0, 32'h0,        1'b0};
        vecs[8]  = '{1'b0, 32'h14,       32'h0,        4'b1111, 0, 32'h0,        1'b0};
        vecs[9]  = '{1'b1, 32'hFC,       32'hAB123456, 4'b1000, 0, 32'h0,        1'b0};
        vecs[10] = '{1'b0, 32'hFC,       32'h0,        4'b1111, 2, 32'hAB000000, 1'b0};
        vecs[11] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'b1111, 0, 32'h0,        1'b1};

        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
        req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_be1 = '0; rsp_ready1 = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_ws0_ready", 32'(req_ready1), 32'd1);

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            model(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, e);
            xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].stall,
                 vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Reset during WAIT drops an uncommitted write.
        model(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, rd, e);
        xact(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, 32'h0, 1'b0, "pre20");
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
        chk("rw_ready_before", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rw_ready_after", 32'(req_ready), 32'd1);
        chk("rw_valid_after", 32'(rsp_valid), 32'd0);
        chk("rw_rdata_after", rsp_rdata, 32'd0);
        chk("rw_err_after", 32'(rsp_err), 32'd0);
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        chk("rw_no_response", 32'(n), 32'd0);
        xact(1'b0, 32'h20, 32'h0, 4'hF, 0, 32'hCAFEF00D, 1'b0, "post20");

        // Reset while a read response is being held.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
        chk("rr_valid_before", 32'(rsp_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rr_valid_after", 32'(rsp_valid), 32'd0);
        chk("rr_rdata_after", rsp_rdata, 32'd0);
        chk("rr_ready_after", 32'(req_ready), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 40; i++) begin
            logic        we;
            logic [31:0] wd;
            logic [3:0]  be;
            int unsigned kind;
            kind = $urandom_range(0, 9);
            we   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            be   = 4'($urandom_range(0, 15));
            if (kind == 0)      a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            else if (kind == 1) a = 32'(DEPTH * 4 + $urandom_range(0, 255) * 4);
            else                a = 32'($urandom_range(0, DEPTH - 1) * 4);
            model(we, a, wd, be, rd, e);
            xact(we, a, wd, be, int'($urandom_range(0, 2)), rd, e, $sformatf("rnd%0d", i));
        end

        // Zero-wait instance: back-to-back requests, rsp_ready tied high.
        @(negedge clk);
        req_valid1 = 1'b1; req_we1 = 1'b1; req_addr1 = 32'h8; req_wdata1 = 32'h11223344; req_be1 = 4'hF;
        acc = 0;
        first = 1'b1;
        for (int c = 0; c < 12; c++) begin
            prev_acc = req_ready1;
            if (req_ready1) acc++;
            @(posedge clk);
            #1;
            if (prev_acc) req_we1 = 1'b0;
            @(negedge clk);
            if (prev_acc) begin
                chk("ws0_rsp_valid", 32'(rsp_valid1), 32'd1);
                chk("ws0_rsp_rdata", rsp_rdata1, first ? 32'h0 : 32'h11223344);
                chk("ws0_rsp_err", 32'(rsp_err1), 32'd0);
                first = 1'b0;
            end else begin
                chk("ws0_idle_valid", 32'(rsp_valid1), 32'd0);
                chk("ws0_idle_ready", 32'(req_ready1), 32'd1);
            end
        end
        req_valid1 = 1'b0;
        chk("ws0_accept_count", 32'(acc), 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 64, meaning the number of 32-bit words stored.
REQ-002 The block SHALL have parameter WAIT_STATES, default 1, meaning the extra cycles between request acceptance and response (range 0..15).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 The block SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 The block SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 The block SHALL have port req_addr  input  32  byte address; word index = req_addr[7:2] at default depth.
REQ-009 The block SHALL have port req_wdata  input  32  write data.
REQ-010 The block SHALL have port req_be  input  4  byte-lane enables; bit i covers wdata[8i+7:8i].
REQ-011 The block SHALL have port rsp_valid  output  1  response is present.
REQ-012 The block SHALL have port rsp_ready  input  1  initiator accepts the response.
REQ-013 The block SHALL have port rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-014 The block SHALL have port rsp_err  output  1  request was misaligned or out of range.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted when req_valid && req_ready; we, addr, wdata, be SHALL be latched that cycle.
REQ-017 On acceptance, the FSM SHALL go IDLE->WAIT if WAIT_STATES>0, else IDLE->RESP, and the wait counter SHALL load WAIT_STATES-1.
REQ-018 WAIT SHALL decrement the counter each cycle and go to RESP on the cycle the counter is 0.
REQ-019 rsp_valid SHALL rise exactly WAIT_STATES+1 cycles after the acceptance edge.
REQ-020 A request SHALL be an error when addr[1:0]!=0 or word index >= DEPTH_WORDS; errors SHALL not modify memory, and SHALL return rsp_err=1, rsp_rdata=0.
REQ-021 A valid write SHALL update only the enabled byte lanes on the edge that enters RESP; be=4'b0000 SHALL leave memory unchanged with rsp_err=0.
REQ-022 A valid read SHALL capture the array word on the edge that enters RESP.
REQ-023 rsp_valid, rsp_rdata and rsp_err SHALL hold stable in RESP while rsp_ready=0.
REQ-024 RESP SHALL go to IDLE on rsp_ready=1; no request SHALL be accepted in that same cycle, so the minimum request period is WAIT_STATES+2 cycles.
REQ-025 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-026 reset SHALL force IDLE with req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0 and counter=0 on the next edge, including mid-transaction.
REQ-027 An in-flight request SHALL be dropped without any response; a write not yet committed SHALL not occur.
REQ-028 Array contents SHALL be retained across reset and SHALL be zero at power-up.

Structure
REQ-029 Package dmem_pkg SHALL hold the state enum, the default DEPTH_WORDS, and the address-LSB constant (2).
REQ-030 The storage SHALL be one sub-module dmem_array: byte-enabled synchronous write and asynchronous read, DEPTH_WORDS x 32.

Verification
REQ-031 Scenario: write 0x12345678 to addr 0x10 with be=1111, then read 0x10 -> rsp_rdata=0x12345678, rsp_err=0, and rsp_valid 2 cycles after each acceptance (default WAIT_STATES).
REQ-032 Scenario: with 0x12345678 at 0x10, write 0xAABBCCDD with be=0101, then read -> rsp_rdata=0x12BB56DD.
REQ-033 Scenario: read 0x13, and write to 0x100 with DEPTH_WORDS=64 -> rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-034 Scenario: hold rsp_ready=0 for 5 cycles during a read response -> rsp_valid and rsp_rdata are stable, req_ready=0 throughout; IDLE is reached on the cycle after rsp_ready=1.
REQ-035 Scenario: assert reset during WAIT of a write of 0xFFFFFFFF to 0x20 -> no response, req_ready=1 on the next cycle, and a later read of 0x20 returns its prior value.
REQ-036 Scenario: WAIT_STATES=0 with back-to-back requests and rsp_ready tied 1 -> response 1 cycle after acceptance, and one accepted request every 2 cycles.
